// File: rtl/bcd_sched_pkg.sv
// Shared types and sizing for the BCD conversion scheduler.
package bcd_sched_pkg;

   localparam int unsigned DATA_W          = 36;
   localparam int unsigned BCD_W           = 44;
   localparam int unsigned DEF_CONV_CYCLES = 38;
   localparam int unsigned ID_W            = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RECOVER = 2'd3
   } state_e;

   // Width of a counter that must reach cycles-1.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Round-robin pick: search begins one past the previous winner; purely combinational.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] sel;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      sel     = '0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         sel = IDX_W'((32'(last_i) + off) % N_REQ);
         if (!valid_o && req_i[sel]) begin
            valid_o    = 1'b1;
            idx_o      = sel;
            gnt_o[sel] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one serial binary-to-BCD engine among N_REQ clients.
// Define BCD_SCHED_ZERO_BYPASS_EN to answer zero operands without running the engine.
module bcd_conv_scheduler
   import bcd_sched_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned CONV_CYCLES = DEF_CONV_CYCLES
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   output logic [N_REQ-1:0]        gnt_o,
   output logic                    done_o,
   output logic [ID_W-1:0]         done_id_o,
   output logic [BCD_W-1:0]        result_o,
   output logic                    busy_o,
   output logic                    eng_enable_o,
   output logic [DATA_W-1:0]       eng_data_o,
   input  logic [BCD_W-1:0]        eng_bcd_i
);

   localparam int unsigned IDX_W     = $clog2(N_REQ);
   localparam int unsigned CNT_W     = cnt_width(CONV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    id_q, id_d;
   logic                bypass_q, bypass_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic                done_q, done_d;
   logic [ID_W-1:0]     done_id_q, done_id_d;
   logic [BCD_W-1:0]    result_q, result_d;
   logic                busy_q, busy_d;
   logic                eng_en_q, eng_en_d;
   logic [DATA_W-1:0]   eng_data_q, eng_data_d;

   logic [N_REQ-1:0]    arb_gnt;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_valid;
   logic [DATA_W-1:0]   win_data;
   logic                zero_win;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i   (req_i),
      .last_i  (last_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Operand of the current arbitration winner.
   always_comb begin
      win_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (arb_gnt[k]) win_data = req_data_i[k*DATA_W +: DATA_W];
      end
   end

`ifdef BCD_SCHED_ZERO_BYPASS_EN
   assign zero_win = (win_data == '0);
`else
   assign zero_win = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // A zero-bypass grant skips CONVERT and lets CAPTURE/RECOVER issue the done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (arb_valid) state_d = zero_win ? ST_CAPTURE : ST_CONVERT;
         ST_CONVERT: if (cnt_q == CNT_LAST) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_RECOVER;
         ST_RECOVER: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      last_d     = last_q;
      id_d       = id_q;
      bypass_d   = bypass_q;
      gnt_d      = '0;
      done_d     = 1'b0;
      done_id_d  = done_id_q;
      result_d   = result_q;
      eng_en_d   = 1'b0;
      eng_data_d = eng_data_q;
      busy_d     = (state_d != ST_IDLE);
      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               gnt_d    = arb_gnt;
               last_d   = arb_idx;
               id_d     = arb_idx;
               cnt_d    = '0;
               bypass_d = zero_win;
               if (!zero_win) begin
                  eng_en_d   = 1'b1;
                  eng_data_d = win_data;
               end
            end
         end
         ST_CONVERT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               done_d    = 1'b1;
               done_id_d = ID_W'(id_q);
               result_d  = eng_bcd_i;
            end else begin
               eng_en_d = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (bypass_q) begin
               done_d    = 1'b1;
               done_id_d = ID_W'(id_q);
               result_d  = '0;
               bypass_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q      <= '0;
         last_q     <= IDX_W'(N_REQ - 1);
         id_q       <= '0;
         bypass_q   <= 1'b0;
         gnt_q      <= '0;
         done_q     <= 1'b0;
         done_id_q  <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         eng_en_q   <= 1'b0;
         eng_data_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         id_q       <= id_d;
         bypass_q   <= bypass_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         done_id_q  <= done_id_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
         eng_en_q   <= eng_en_d;
         eng_data_q <= eng_data_d;
      end
   end

   assign gnt_o        = gnt_q;
   assign done_o       = done_q;
   assign done_id_o    = done_id_q;
   assign result_o     = result_q;
   assign busy_o       = busy_q;
   assign eng_enable_o = eng_en_q;
   assign eng_data_o   = eng_data_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler with a behavioural serial engine and a result scoreboard.
module tb_bcd_conv_scheduler;
   import bcd_sched_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned CC = 38;
`ifdef BCD_SCHED_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef struct {int id; int busy;} gnt_t;
   typedef struct {int id; logic [BCD_W-1:0] bcd; int lat; int en;} done_t;

   logic                clk;
   logic                reset;
   logic [N-1:0]        req;
   logic [N*DATA_W-1:0] req_data;
   logic [N-1:0]        gnt;
   logic                done;
   logic [ID_W-1:0]     done_id;
   logic [BCD_W-1:0]    result;
   logic                busy;
   logic                eng_enable;
   logic [DATA_W-1:0]   eng_data;
   logic [BCD_W-1:0]    eng_bcd = '0;
   logic [5:0]          ecnt = '0;

   gnt_t  gq[$];
   done_t dq[$];
   gnt_t  g;
   done_t d;
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    g_cyc = 0;
   int    en_cnt = 0;
   int    busy_len = 0;
   int    busy_exp = -1;
   int    g1 = 0;

   bcd_conv_scheduler #(.N_REQ(N), .CONV_CYCLES(CC)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .req_i        (req),
      .req_data_i   (req_data),
      .gnt_o        (gnt),
      .done_o       (done),
      .done_id_o    (done_id),
      .result_o     (result),
      .busy_o       (busy),
      .eng_enable_o (eng_enable),
      .eng_data_o   (eng_data),
      .eng_bcd_i    (eng_bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input bit ok, input longint obs, input longint ex);
      checks++;
      if (!ok) begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
      end
   endtask

   function automatic logic [BCD_W-1:0] to_bcd(input logic [DATA_W-1:0] v);
      longint unsigned x = 64'(v);
      logic [BCD_W-1:0] r = '0;
      for (int i = 0; i < 11; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Engine: output correct only in the final enabled cycle, garbage elsewhere.
   always @(posedge clk) begin
      if (!eng_enable) ecnt <= '0;
      else begin
         ecnt <= ecnt + 6'd1;
         if (ecnt == 6'(CC - 2)) eng_bcd <= to_bcd(eng_data);
         else                    eng_bcd <= {8'hEE, eng_data ^ 36'hA_5A5A_5A5A};
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: grants and done pulses are matched against the scoreboard queues.
   always @(negedge clk) begin
      if (!reset) begin
         if (gnt != '0) begin
            chk("gnt_expected", gq.size() > 0, gq.size(), 1);
            chk("gnt_onehot", $onehot(gnt) === 1'b1, gnt, 1);
            if (gq.size() > 0) begin
               g = gq.pop_front();
               chk("gnt_id", gnt === 4'(1 << g.id), gnt, 4'(1 << g.id));
               busy_exp = g.busy;
            end
            g_cyc  = cyc;
            en_cnt = 0;
         end
         if (eng_enable) en_cnt++;
         if (done) begin
            chk("done_expected", dq.size() > 0, dq.size(), 1);
            if (dq.size() > 0) begin
               d = dq.pop_front();
               chk("done_id", int'(done_id) == d.id, done_id, d.id);
               chk("result", result === d.bcd, result, d.bcd);
               chk("done_latency", (cyc - g_cyc) == d.lat, cyc - g_cyc, d.lat);
               chk("enable_cycles", en_cnt == d.en, en_cnt, d.en);
            end
         end
      end
      if (busy) busy_len++;
      else begin
         if (busy_len > 0 && busy_exp >= 0) chk("busy_len", busy_len == busy_exp, busy_len, busy_exp);
         busy_len = 0;
      end
   end

   task automatic set_req(input int k, input logic [DATA_W-1:0] v);
      req[k] = 1'b1;
      req_data[k*DATA_W +: DATA_W] = v;
   endtask

   task automatic wait_gnt(input int k);
      bit seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         seen = gnt[k];
      end
      chk("gnt_wait", seen == 1'b1, seen, 1);
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int n = 0; n < 300 && !idle; n++) begin
         @(negedge clk);
         idle = !busy && (dq.size() == 0);
      end
      chk("idle_wait", idle == 1'b1, idle, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", gnt === 4'h0, gnt, 0);
      chk("rst_done", done === 1'b0, done, 0);
      chk("rst_done_id", done_id === 3'd0, done_id, 0);
      chk("rst_result", result === 44'h0, result, 0);
      chk("rst_busy", busy === 1'b0, busy, 0);
      chk("rst_eng_enable", eng_enable === 1'b0, eng_enable, 0);
      chk("rst_eng_data", eng_data === 36'h0, eng_data, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Single conversion; a req pulse confined to the busy window must be ignored.
      gq.push_back(gnt_t'{0, 40});
      dq.push_back(done_t'{0, 44'h123456789, CC, CC});
      set_req(0, 36'd123456789);
      wait_gnt(0);
      req[0] = 1'b0;
      repeat (5) @(negedge clk);
      req[3] = 1'b1;
      repeat (3) @(negedge clk);
      req[3] = 1'b0;
      wait_idle();

      // Two simultaneous requesters, granted 41 cycles apart.
      gq.push_back(gnt_t'{1, 40});
      gq.push_back(gnt_t'{3, 40});
      dq.push_back(done_t'{1, 44'h999, CC, CC});
      dq.push_back(done_t'{3, 44'h68000000000, CC, CC});
      set_req(1, 36'd999);
      set_req(3, 36'd68000000000);
      wait_gnt(1);
      g1 = cyc;
      req[1] = 1'b0;
      wait_gnt(3);
      chk("gnt_spacing", (cyc - g1) == 41, cyc - g1, 41);
      req[3] = 1'b0;
      wait_idle();

      // All four held: strict rotation over eight conversions.
      for (int i = 0; i < 8; i++) begin
         gq.push_back(gnt_t'{i % 4, 40});
         dq.push_back(done_t'{i % 4, 44'(((i % 4) + 1) * 'h11), CC, CC});
      end
      set_req(0, 36'd11);
      set_req(1, 36'd22);
      set_req(2, 36'd33);
      set_req(3, 36'd44);
      for (int i = 0; i < 8; i++) wait_gnt(i % 4);
      req = '0;
      wait_idle();

      // Reset in the middle of a conversion aborts it without a done.
      gq.push_back(gnt_t'{0, -1});
      set_req(0, 36'd5);
      wait_gnt(0);
      req[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_gnt", gnt === 4'h0, gnt, 0);
      chk("abort_done", done === 1'b0, done, 0);
      chk("abort_done_id", done_id === 3'd0, done_id, 0);
      chk("abort_result", result === 44'h0, result, 0);
      chk("abort_busy", busy === 1'b0, busy, 0);
      chk("abort_eng_enable", eng_enable === 1'b0, eng_enable, 0);
      chk("abort_eng_data", eng_data === 36'h0, eng_data, 0);
      repeat (3) @(negedge clk);
      gq.push_back(gnt_t'{2, 40});
      dq.push_back(done_t'{2, 44'h987654321, CC, CC});
      set_req(2, 36'd987654321);
      wait_gnt(2);
      req[2] = 1'b0;
      wait_idle();

      // Largest operand, then result and engine operand hold while idle.
      gq.push_back(gnt_t'{2, 40});
      dq.push_back(done_t'{2, 44'h68719476735, CC, CC});
      set_req(2, 36'hF_FFFF_FFFF);
      wait_gnt(2);
      req[2] = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("result_hold", result === 44'h68719476735, result, 44'h68719476735);
      chk("eng_data_hold", eng_data === 36'hF_FFFF_FFFF, eng_data, 36'hF_FFFF_FFFF);

      // Zero operand: bypass or full engine path depending on the build.
      gq.push_back(gnt_t'{1, BYPASS ? 2 : 40});
      dq.push_back(done_t'{1, 44'h0, BYPASS ? 1 : int'(CC), BYPASS ? 0 : int'(CC)});
      set_req(1, 36'd0);
      wait_gnt(1);
      req[1] = 1'b0;
      wait_idle();
      chk("eng_data_after_zero", eng_data === (BYPASS ? 36'hF_FFFF_FFFF : 36'h0),
          eng_data, BYPASS ? 36'hF_FFFF_FFFF : 36'h0);

      repeat (4) @(negedge clk);
      chk("queues_drained", (gq.size() + dq.size()) == 0, gq.size() + dq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
- Shares one serial binary-to-BCD conversion engine (36-bit binary in, 11-digit / 44-bit BCD out) between N_REQ requesters.
- Arbitrates round-robin and latches the winner's operand onto the engine.
- Holds the engine enable high for a fixed number of cycles, then captures the BCD result and returns it with a done pulse tagged by requester ID.
- Sits between the front-panel/datapath clients and the conversion engine; it is the engine's only driver.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 36, binary operand width.
- BCD_W, 44, BCD result width (11 digits).
- CONV_CYCLES, 38, consecutive cycles eng_enable is held high per conversion (DATA_W+2).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_data  in  N_REQ*DATA_W  operands; requester k uses slice [k*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot, one-cycle grant pulse.
- done  out  1  one-cycle result-valid pulse.
- done_id  out  3  index of the requester whose result is on `result`.
- result  out  BCD_W  captured BCD value; holds until the next done.
- busy  out  1  high in any state other than IDLE.
- eng_enable  out  1  engine enable.
- eng_data  out  DATA_W  operand presented to the engine; stable during the whole conversion.
- eng_bcd  in  BCD_W  engine BCD output.

Behaviour:
- Reset values: state IDLE, gnt=0, done=0, done_id=0, result=0, busy=0, eng_enable=0, eng_data=0, rr pointer last=N_REQ-1 (requester 0 wins first).
- States:
  - IDLE: if any req, pick the winner and go to CONVERT.
  - CONVERT: cycle counter runs 0..CONV_CYCLES-1, then go to CAPTURE.
  - CAPTURE: go to RECOVER.
  - RECOVER: go to IDLE.
- Arbitration:
  - Evaluated in IDLE.
  - Search starts at last+1 modulo N_REQ; the first asserted req wins.
  - last is updated to the winner.
  - Requests arriving while busy wait; they are never lost if held.
- Handshake:
  - Requester holds req and its req_data until it sees its gnt bit.
  - Operand is latched into eng_data on the IDLE→CONVERT edge.
  - Requester may drop or change req_data from the gnt cycle onward.
  - Holding req after gnt counts as a new request; it is serviced again after other pending requesters.
- Timing (G = gnt cycle):
  - eng_enable is high in cycles G..G+CONV_CYCLES-1. gnt and CONVERT share cycle G.
  - CAPTURE at G+CONV_CYCLES:
    - done=1, done_id=winner, result = eng_bcd as sampled at the end of cycle G+CONV_CYCLES-1.
    - eng_enable=0.
  - RECOVER at G+CONV_CYCLES+1: eng_enable low so the engine clears its bit counter.
  - IDLE at G+CONV_CYCLES+2.
  - Earliest next gnt is G+CONV_CYCLES+3, giving a period of 41 cycles at defaults.
- eng_data holds its value after completion until the next grant.
- Reset mid-conversion: takes effect on the next edge. All outputs return to reset values, no done is issued, and the aborted requester must re-request.
- A req bit asserted only in non-IDLE cycles and dropped before IDLE is never granted.

Optional Feature:
- Macro: BCD_SCHED_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the winner's operand is 0, gnt pulses at G without enabling the engine.
  - done at G+1 with result=0 and correct done_id, then return to IDLE at G+2.
  - eng_enable never rises and eng_data is not updated.
- Undefined: zero operands take the full engine path. Result is still 0, with the normal CONV_CYCLES latency.

Decomposition:
- Shared package bcd_sched_pkg:
  - state enum (IDLE, CONVERT, CAPTURE, RECOVER).
  - localparams DATA_W=36, BCD_W=44, DEF_CONV_CYCLES=38.
  - function computing counter width from CONV_CYCLES.
- One sub-module: rr_arbiter (req vector plus last pointer in, one-hot grant and index out, purely combinational).

Test Plan:
- Reset, then req[0]=1 with data 36'd123456789 → gnt[0] one cycle. eng_enable high 38 cycles. done 38 cycles after gnt with result=44'h00_0012_3456_789 and done_id=0. busy high for 40 cycles.
- req[1] and req[3] asserted together, held until granted → gnt[1] first, then gnt[3] exactly 41 cycles later. done_ids 1 then 3, each with the correct BCD.
- All four requests held continuously for 8 conversions → grant order 0,1,2,3,0,1,2,3, with no requester starved.
- Reset pulsed at cycle G+10 of a conversion → outputs zero next cycle, no done pulse. A new req[2] afterwards completes normally.
- Max operand 36'hF_FFFF_FFFF on req[2] → result=44'h068_7194_7673_5 (decimal 68719476735).
- Zero operand on req[1] → with BCD_SCHED_ZERO_BYPASS_EN: done at G+1, eng_enable stays 0. Without it: done at G+38 with result=0.
